// File: rtl/lpif_txrx_x16_asym1_half_ll_txfifo.sv
// rtl/lpif_txrx_x16_asym1_half_ll_txfifo.sv - link-layer transmit FIFO with registered show-ahead head word
module lpif_txrx_x16_asym1_half_ll_txfifo #(
    parameter int WIDTH = 1074,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_wr,
    input  logic             rst_wr_n,
    input  logic [WIDTH-1:0] txfifo_upstream_data,
    input  logic             user_upstream_vld,
    output logic             user_upstream_ready,
    output logic [WIDTH-1:0] tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [AW:0]      fifo_count,
    output logic             fifo_full,
    output logic             fifo_empty,
    output logic             overflow_sticky,
    input  logic             overflow_clr,
    input  logic             m_gen2_mode
);

    localparam int HALF = WIDTH / 2;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_tx_data;
    logic             r_overflow;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [AW-1:0]    w_rd_next;
    logic [AW:0]      w_remain;
    logic [WIDTH-1:0] w_wdata;

    assign w_full    = (r_count == (AW+1)'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_push    = user_upstream_vld && !w_full;
    assign w_pop     = !w_empty && tx_ready;
    assign w_rd_next = r_rd_ptr + AW'(w_pop);
    // Entries left after this cycle's pop, excluding this cycle's push.
    assign w_remain  = r_count - (AW+1)'(w_pop);

    // Gen1 carries only half-channel 0; the upper half is zeroed on entry.
    always_comb begin
        w_wdata = txfifo_upstream_data;
        if (!m_gen2_mode) begin
            w_wdata[WIDTH-1:HALF] = '0;
        end
    end

    always_ff @(posedge clk_wr) begin
        if (w_push && rst_wr_n) begin
            r_mem[r_wr_ptr] <= w_wdata;
        end
    end

    always_ff @(posedge clk_wr) begin
        if (!rst_wr_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_tx_data  <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_rd_ptr <= w_rd_next;
            r_count  <= w_remain + (AW+1)'(w_push);
            // A push into a FIFO that is (or becomes) empty lands directly at the head.
            if (w_push && (w_remain == '0)) begin
                r_tx_data <= w_wdata;
            end else begin
                r_tx_data <= r_mem[w_rd_next];
            end
            if (user_upstream_vld && w_full) begin
                r_overflow <= 1'b1;
            end else if (overflow_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign user_upstream_ready = !w_full;
    assign tx_data             = r_tx_data;
    assign tx_valid            = !w_empty;
    assign fifo_count          = r_count;
    assign fifo_full           = w_full;
    assign fifo_empty          = w_empty;
    assign overflow_sticky     = r_overflow;

endmodule

// File: tb/tb_lpif_txrx_x16_asym1_half_ll_txfifo.sv
// tb/tb_lpif_txrx_x16_asym1_half_ll_txfifo.sv - directed self-checking bench for the transmit FIFO
module tb_lpif_txrx_x16_asym1_half_ll_txfifo;

    localparam int WIDTH = 1074;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic             clk_wr = 1'b0;
    logic             rst_wr_n;
    logic [WIDTH-1:0] txfifo_upstream_data;
    logic             user_upstream_vld;
    logic             user_upstream_ready;
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [AW:0]      fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             overflow_sticky;
    logic             overflow_clr;
    logic             m_gen2_mode;

    int checks   = 0;
    int failures = 0;

    lpif_txrx_x16_asym1_half_ll_txfifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk_wr               (clk_wr),
        .rst_wr_n             (rst_wr_n),
        .txfifo_upstream_data (txfifo_upstream_data),
        .user_upstream_vld    (user_upstream_vld),
        .user_upstream_ready  (user_upstream_ready),
        .tx_data              (tx_data),
        .tx_valid             (tx_valid),
        .tx_ready             (tx_ready),
        .fifo_count           (fifo_count),
        .fifo_full            (fifo_full),
        .fifo_empty           (fifo_empty),
        .overflow_sticky      (overflow_sticky),
        .overflow_clr         (overflow_clr),
        .m_gen2_mode          (m_gen2_mode)
    );

    always #5 clk_wr = ~clk_wr;

    task automatic tick();
        @(posedge clk_wr);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [WIDTH-1:0] ones;
        logic [WIDTH-1:0] data;
        ones = '1;
        rst_wr_n = 1'b0;
        txfifo_upstream_data = '0;
        user_upstream_vld = 1'b0;
        tx_ready = 1'b0;
        overflow_clr = 1'b0;
        m_gen2_mode = 1'b1;
        tick();
        tick();
        rst_wr_n = 1'b1;
        tick();

        chk("rst_valid", 64'(tx_valid), 64'd0);
        chk("rst_empty", 64'(fifo_empty), 64'd1);
        chk("rst_full", 64'(fifo_full), 64'd0);
        chk("rst_count", 64'(fifo_count), 64'd0);
        chk("rst_ready", 64'(user_upstream_ready), 64'd1);
        chk("rst_ovf", 64'(overflow_sticky), 64'd0);
        chk("rst_data", 64'(tx_data == '0), 64'd1);

        // Three pushes with the consumer stalled, then drain in order.
        user_upstream_vld = 1'b1;
        txfifo_upstream_data = WIDTH'(1);
        tick();
        chk("first_valid", 64'(tx_valid), 64'd1);
        chk("first_data", tx_data[63:0], 64'h1);
        txfifo_upstream_data = WIDTH'(2);
        tick();
        txfifo_upstream_data = WIDTH'(3);
        tick();
        user_upstream_vld = 1'b0;
        chk("cnt3", 64'(fifo_count), 64'd3);
        chk("hold_data", tx_data[63:0], 64'h1);
        tx_ready = 1'b1;
        tick();
        chk("pop1_data", tx_data[63:0], 64'h2);
        chk("pop1_cnt", 64'(fifo_count), 64'd2);
        tick();
        chk("pop2_data", tx_data[63:0], 64'h3);
        tick();
        chk("drain_cnt", 64'(fifo_count), 64'd0);
        chk("drain_valid", 64'(tx_valid), 64'd0);
        tick();
        chk("pop_empty_cnt", 64'(fifo_count), 64'd0);
        tx_ready = 1'b0;

        // Fill to DEPTH, then one extra push overflows.
        user_upstream_vld = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            txfifo_upstream_data = WIDTH'(16 + i);
            tick();
        end
        chk("full_flag", 64'(fifo_full), 64'd1);
        chk("full_ready", 64'(user_upstream_ready), 64'd0);
        chk("full_cnt", 64'(fifo_count), 64'd8);
        chk("full_ovf0", 64'(overflow_sticky), 64'd0);
        txfifo_upstream_data = WIDTH'(99);
        tick();
        user_upstream_vld = 1'b0;
        chk("ovf_set", 64'(overflow_sticky), 64'd1);
        chk("ovf_cnt", 64'(fifo_count), 64'd8);
        chk("ovf_head", tx_data[63:0], 64'd16);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        chk("ovf_clr", 64'(overflow_sticky), 64'd0);

        // Full: simultaneous push and pop pops only; the push also flags overflow.
        user_upstream_vld = 1'b1;
        tx_ready = 1'b1;
        overflow_clr = 1'b1;
        txfifo_upstream_data = WIDTH'(8'h77);
        tick();
        user_upstream_vld = 1'b0;
        tx_ready = 1'b0;
        overflow_clr = 1'b0;
        chk("fullpp_cnt", 64'(fifo_count), 64'd7);
        chk("fullpp_ovf_setwins", 64'(overflow_sticky), 64'd1);
        tx_ready = 1'b1;
        for (int i = 1; i < DEPTH; i++) begin
            chk($sformatf("fullpp_order%0d", i), tx_data[63:0], 64'(16 + i));
            tick();
        end
        tx_ready = 1'b0;
        chk("fullpp_dropped", 64'(fifo_count), 64'd0);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;

        // Steady state at count 4 across pointer wrap.
        user_upstream_vld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            txfifo_upstream_data = WIDTH'(256 + i);
            tick();
        end
        tx_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("wrap_head%0d", i), tx_data[63:0], 64'(256 + i));
            txfifo_upstream_data = WIDTH'(260 + i);
            tick();
            chk($sformatf("wrap_cnt%0d", i), 64'(fifo_count), 64'd4);
        end
        user_upstream_vld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("wrap_tail%0d", i), tx_data[63:0], 64'(276 + i));
            tick();
        end
        tx_ready = 1'b0;
        chk("wrap_empty", 64'(fifo_empty), 64'd1);

        // Gen1 masks the upper half-channel; gen2 keeps all bits.
        m_gen2_mode = 1'b0;
        user_upstream_vld = 1'b1;
        txfifo_upstream_data = ones;
        tick();
        m_gen2_mode = 1'b1;
        tick();
        user_upstream_vld = 1'b0;
        chk("gen1_low_ones", 64'(tx_data[536:0] == ones[536:0]), 64'd1);
        chk("gen1_high_zero", 64'(tx_data[1073:537] == '0), 64'd1);
        tx_ready = 1'b1;
        tick();
        chk("gen2_all_ones", 64'(tx_data == ones), 64'd1);
        tick();
        tx_ready = 1'b0;
        chk("gen_empty", 64'(fifo_count), 64'd0);

        // Reset with a concurrent push discards everything.
        user_upstream_vld = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data = WIDTH'(80 + i);
            txfifo_upstream_data = data;
            tick();
        end
        chk("pre_rst_cnt", 64'(fifo_count), 64'd5);
        rst_wr_n = 1'b0;
        txfifo_upstream_data = WIDTH'(12'hABC);
        tick();
        rst_wr_n = 1'b1;
        user_upstream_vld = 1'b0;
        chk("midrst_cnt", 64'(fifo_count), 64'd0);
        chk("midrst_valid", 64'(tx_valid), 64'd0);
        chk("midrst_empty", 64'(fifo_empty), 64'd1);
        chk("midrst_data", 64'(tx_data == '0), 64'd1);
        user_upstream_vld = 1'b1;
        txfifo_upstream_data = WIDTH'(5);
        tick();
        user_upstream_vld = 1'b0;
        chk("postrst_head", tx_data[63:0], 64'd5);
        chk("postrst_cnt", 64'(fifo_count), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
